// File: rtl/ram_pkg.sv
// Shared defaults and FSM state encoding for the RAM burst controller.
package ram_pkg;

  localparam int RAM_ADDR_W = 12;
  localparam int RAM_DATA_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_TURN
  } state_t;

endpackage

// File: rtl/ram_burst_ctrl_if.sv
// Command, write-beat and read-beat handshake bundle for ram_burst_ctrl.
interface ram_burst_ctrl_if
  import ram_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W,
  parameter int LEN_W  = 4
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic              wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              busy;

  modport master (
    output cmd_valid, cmd_we, cmd_addr, cmd_len, wr_valid, wr_data,
    input  cmd_ready, wr_ready, rd_valid, rd_data, busy
  );

  modport slave (
    input  cmd_valid, cmd_we, cmd_addr, cmd_len, wr_valid, wr_data,
    output cmd_ready, wr_ready, rd_valid, rd_data, busy
  );

endinterface

// File: rtl/ram_bus_drv.sv
// RAM data-bus tristate driver and read-capture pipeline.
module ram_bus_drv #(
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              drive,
  input  logic [DATA_W-1:0] wdata,
  input  logic              issue,
  inout  wire  [DATA_W-1:0] ram_data,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data
);

  logic [RD_LAT-1:0] pend;

  assign ram_data = drive ? wdata : 'z;

  // Track each issued read address for RD_LAT cycles, then capture the bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend     <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      pend[0] <= issue;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        pend[i] <= pend[i-1];
      end
      rd_valid <= pend[RD_LAT-1];
      if (pend[RD_LAT-1]) begin
        rd_data <= ram_data;
      end
    end
  end

endmodule

// File: rtl/ram_burst_ctrl.sv
// Burst controller for a single-port synchronous RAM with shared data bus.
module ram_burst_ctrl
  import ram_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W,
  parameter int LEN_W  = 4,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  ram_burst_ctrl_if.slave   bus,
  output logic              ram_rw,
  output logic [ADDR_W-1:0] ram_addr,
  inout  wire  [DATA_W-1:0] ram_data
);

  localparam int CNT_W = LEN_W + 1;
  localparam int DR_W  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  cnt;
  logic [DR_W-1:0]   drain;
  logic              issue;

  assign bus.cmd_ready = (state == S_IDLE);
  assign bus.wr_ready  = (state == S_WRITE);
  assign bus.busy      = (state != S_IDLE);
  // Write strobe follows wr_valid in the same cycle so the beat lands on this edge.
  assign ram_rw        = (state == S_WRITE) && bus.wr_valid;
  assign ram_addr      = addr;
  assign issue         = (state == S_READ);

  // Burst sequencing: command latch, beat counting, read drain and turnaround.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      addr  <= '0;
      cnt   <= '0;
      drain <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            addr  <= bus.cmd_addr;
            cnt   <= {1'b0, bus.cmd_len} + 1'b1;
            state <= bus.cmd_we ? S_WRITE : S_READ;
          end
        end
        S_WRITE: begin
          if (bus.wr_valid) begin
            addr <= addr + 1'b1;
            cnt  <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) state <= S_IDLE;
          end
        end
        S_READ: begin
          addr <= addr + 1'b1;
          cnt  <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            drain <= '0;
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (drain == DR_W'(RD_LAT - 1)) state <= S_TURN;
          else drain <= drain + 1'b1;
        end
        S_TURN: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  ram_bus_drv #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_drv (
    .clk      (clk),
    .rst      (rst),
    .drive    (ram_rw),
    .wdata    (bus.wr_data),
    .issue    (issue),
    .ram_data (ram_data),
    .rd_valid (bus.rd_valid),
    .rd_data  (bus.rd_data)
  );

endmodule

// File: doc/ram_burst_ctrl.md
RAM_BURST_CTRL -- requirements
Module: ram_burst_ctrl

Interface
REQ-001 Parameter ADDR_W, default 12, RAM address width.
REQ-002 Parameter DATA_W, default 16, RAM data width.
REQ-003 Parameter LEN_W, default 4, burst-length field width; the maximum burst is 2^LEN_W beats.
REQ-004 Parameter RD_LAT, default 1, the number of cycles from a read address on ram_addr to valid data on ram_data.
REQ-005 One clock; reset is synchronous and active-high. Ports: clk input 1, the single clock; rst input 1, synchronous active-high reset.
REQ-006 cmd_valid input 1, command request; cmd_ready output 1, controller accepts a command.
REQ-007 cmd_we input 1, 1 = write burst, 0 = read burst; cmd_addr input ADDR_W, start address; cmd_len input LEN_W, beats minus 1.
REQ-008 wr_valid input 1 and wr_data input DATA_W carry write beats; wr_ready output 1, beat consumed.
REQ-009 rd_valid output 1 and rd_data output DATA_W carry read beats, with no backpressure.
REQ-010 busy output 1, high whenever the state is not IDLE.
REQ-011 RAM side: ram_rw output 1 (1 = write); ram_addr output ADDR_W; ram_data inout DATA_W.

Function
REQ-012 FSM states: IDLE, WRITE, READ, DRAIN, TURN.
REQ-013 IDLE: cmd_ready=1; on cmd_valid, latch addr/len/we; go to WRITE if we=1, otherwise READ.
REQ-014 cmd_ready SHALL be 0 in every state other than IDLE.
REQ-015 WRITE: wr_ready=1; on each wr_valid&wr_ready cycle: ram_rw=1, ram_addr=current addr, ram_data driven with wr_data (combinational pass-through in that cycle); the RAM captures on that rising edge.
REQ-016 WRITE stall: when wr_valid=0, ram_rw=0, ram_data is hi-Z, and the address and count hold.
REQ-017 WRITE end: after beat len+1 is accepted, go directly to IDLE.
REQ-018 READ: ram_rw=0, ram_data is hi-Z, and one address is issued per cycle for len+1 consecutive cycles.
REQ-019 READ end: after the last address is issued, go to DRAIN.
REQ-020 Read data on ram_data SHALL be registered into rd_data RD_LAT cycles after each address issue.
REQ-021 rd_valid SHALL pulse for exactly one cycle per beat, with beats in address order.
REQ-022 DRAIN: remain until all outstanding beats have returned (RD_LAT cycles), then go to TURN.
REQ-023 TURN: one idle cycle with ram_rw=0 and the bus hi-Z (read-to-write turnaround), then go to IDLE.
REQ-024 Address increment SHALL be modulo 2^ADDR_W (12'hFFF+1 = 12'h000, no error flag).
REQ-025 Beat count SHALL be LEN_W+1 bits wide; cmd_len all-ones gives 2^LEN_W beats.
REQ-026 The controller SHALL drive ram_data only while ram_rw=1; it SHALL never drive ram_data with ram_rw=0.
REQ-027 A new command SHALL be accepted no earlier than the cycle after a WRITE burst ends, or the cycle after TURN.
REQ-028 ram_rw, ram_addr, rd_valid, rd_data, cmd_ready and busy SHALL be glitch-free registered or decoded-from-state outputs.

Reset
REQ-029 On rst=1 at a clock edge: state=IDLE, ram_rw=0, ram_addr=0, ram_data hi-Z, rd_valid=0, rd_data=0, wr_ready=0, busy=0; cmd_ready=1 from the first cycle after reset release.
REQ-030 Reset mid-burst SHALL abort the burst: no further writes, in-flight read beats dropped (no rd_valid after reset), counters cleared.

Structure
REQ-031 Package ram_pkg SHALL hold ADDR_W/DATA_W defaults and the FSM state enumeration.
REQ-032 One sub-module, ram_bus_drv, SHALL hold the tristate driver and read-capture pipeline (RD_LAT-deep valid shift register plus data register).
REQ-033 The block SHALL connect directly to ram4096X16 ports clk/rw/addr/data with no glue logic.

Verification
REQ-034 Write burst: addr=12'h3FE, len=3, data 16'hA000..A003, wr_valid held high -> RAM locations 3FE,3FF,400,401 hold A000..A003; 4 wr_ready handshakes; busy for 4 cycles.
REQ-035 Read-back: addr=12'h3FE, len=3 -> rd_valid 4 consecutive cycles starting RD_LAT+1 cycles after acceptance; rd_data=A000..A003; then one TURN cycle.
REQ-036 Wrap: write addr=12'hFFE, len=2, data 1,2,3 -> locations FFE=1, FFF=2, 000=3; the read returns 1,2,3.
REQ-037 Write stall: wr_valid low on beats 2 and 3 for 2 cycles each -> ram_rw=0 and bus hi-Z during stalls; the final contents are unchanged from the unstalled case.
REQ-038 Turnaround: read len=0 immediately followed by write cmd_valid -> the write is accepted only after TURN; no cycle has ram_rw=1 while the RAM drives the bus (no X on ram_data).
REQ-039 Reset mid-read: assert rst during the 3rd issue cycle of a len=7 read -> rd_valid stays 0 afterwards, cmd_ready=1 after release, and a following len=0 write completes normally.
